// File: rtl/alu_pkg.sv
// Shared types for the digit-serial ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_XOR    = 3'b110
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } dsalu_state_e;

endpackage

// File: rtl/digit_serial_alu_if.sv
// Operand/result handshake bundle between the issuing stage and the digit-serial ALU.
interface digit_serial_alu_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input_A;
  logic [WIDTH-1:0] input_B;
  logic [2:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, input_A, input_B, control, out_ready,
    input  in_ready, out_valid, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, input_A, input_B, control, out_ready,
    output in_ready, out_valid, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU cell; b arrives already inverted for subtraction.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [2:0]       control,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] sum;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    y     = '0;
    cout  = 1'b0;
    c_msb = 1'b0;
    case (control)
      ALU_PASS_B: y = b;
      ALU_ADD, ALU_SUB: begin
        y     = sum[SLICE-1:0];
        cout  = sum[SLICE];
        // carry into the MSB recovered from the MSB sum bit and its operands
        c_msb = sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: WIDTH-bit operation processed SLICE bits per cycle with rippled carry.
// Define DIGIT_SERIAL_ALU_FLAGS_EN to build the N/Z/V/C flag registers; otherwise flags read 0.
//
//   state  | meaning
//   S_IDLE | ready for operands; in_ready high
//   S_RUN  | one slice per cycle, counter k selects the slice
//   S_DONE | result/flags held, out_valid high until out_ready
module digit_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic               clk,
  input  logic               reset,
  digit_serial_alu_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("digit_serial_alu: WIDTH must be a multiple of SLICE");
  end

  dsalu_state_e     state, state_next;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg, result_next;
  logic [2:0]       ctrl_reg;
  logic             carry_reg;
  logic             in_ready, out_valid, accept, last;
  logic [31:0]      base;
  logic [SLICE-1:0] s_y;
  logic             s_cout, s_cmsb;

  assign last   = (k == LAST);
  assign accept = bus.in_valid & in_ready;
  assign base   = 32'(k) * 32'(SLICE);

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a       (a_reg[base +: SLICE]),
    .b       (b_reg[base +: SLICE]),
    .cin     (carry_reg),
    .control (ctrl_reg),
    .y       (s_y),
    .cout    (s_cout),
    .c_msb   (s_cmsb)
  );

  always_comb begin
    result_next = result_reg;
    result_next[base +: SLICE] = s_y;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = S_RUN;
      end
      S_RUN:  if (last) state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k          <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      ctrl_reg   <= '0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
    end else if (accept) begin
      k         <= '0;
      a_reg     <= bus.input_A;
      // only subtraction uses the inverted operand and a carry-in of 1
      b_reg     <= (bus.control == ALU_SUB) ? ~bus.input_B : bus.input_B;
      ctrl_reg  <= bus.control;
      carry_reg <= (bus.control == ALU_SUB);
    end else if (state == S_RUN) begin
      result_reg <= result_next;
      carry_reg  <= s_cout;
      k          <= last ? '0 : k + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_reg;

`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
  logic n_reg, z_reg, v_reg, c_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg <= 1'b0;
      z_reg <= 1'b0;
      v_reg <= 1'b0;
      c_reg <= 1'b0;
    end else if (state == S_RUN && last) begin
      n_reg <= result_next[WIDTH-1];
      z_reg <= (result_next == '0);
      v_reg <= s_cmsb ^ s_cout;
      c_reg <= s_cout;
    end
  end

  assign bus.negative  = n_reg;
  assign bus.zero      = z_reg;
  assign bus.overflow  = v_reg;
  assign bus.carry_out = c_reg;
`else
  logic unused_flag_src;
  assign unused_flag_src = s_cmsb;

  assign bus.negative  = 1'b0;
  assign bus.zero      = 1'b0;
  assign bus.overflow  = 1'b0;
  assign bus.carry_out = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_alu.sv
// Directed bench for digit_serial_alu: a 64/16 instance and a 64/64 instance.
module tb_digit_serial_alu;
  import alu_pkg::*;

  typedef struct {
    logic [2:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  nzvc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        iv [2];
  logic        ordy [2];
  logic [63:0] ia [2];
  logic [63:0] ib [2];
  logic [2:0]  ic [2];
  logic        ir [2];
  logic        ov [2];
  logic [63:0] res [2];
  logic [3:0]  flg [2];

  int total = 0;
  int bad = 0;

  digit_serial_alu_if #(.WIDTH(64)) if0 ();
  digit_serial_alu_if #(.WIDTH(64)) if1 ();

  assign if0.in_valid = iv[0];
  assign if0.out_ready = ordy[0];
  assign if0.input_A = ia[0];
  assign if0.input_B = ib[0];
  assign if0.control = ic[0];
  assign ir[0] = if0.in_ready;
  assign ov[0] = if0.out_valid;
  assign res[0] = if0.result;
  assign flg[0] = {if0.negative, if0.zero, if0.overflow, if0.carry_out};

  assign if1.in_valid = iv[1];
  assign if1.out_ready = ordy[1];
  assign if1.input_A = ia[1];
  assign if1.input_B = ib[1];
  assign if1.control = ic[1];
  assign ir[1] = if1.in_ready;
  assign ov[1] = if1.out_valid;
  assign res[1] = if1.result;
  assign flg[1] = {if1.negative, if1.zero, if1.overflow, if1.carry_out};

  digit_serial_alu #(.WIDTH(64), .SLICE(16)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  digit_serial_alu #(.WIDTH(64), .SLICE(64)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  function automatic logic [3:0] fexp(input logic [3:0] nzvc);
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
    return nzvc;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic start_op(input int d, input logic [2:0] ctrl, input logic [63:0] a, input logic [63:0] b);
    int w;
    @(negedge clk);
    ic[d] = ctrl;
    ia[d] = a;
    ib[d] = b;
    iv[d] = 1'b1;
    w = 0;
    while (!ir[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ir[d]) chk("accept_timeout", 64'(ir[d]), 64'd1);
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    ia[d] = {$urandom, $urandom};
    ib[d] = {$urandom, $urandom};
    ic[d] = 3'($urandom_range(7));
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ov[d]) break;
    end
  endtask

  task automatic run_vec(input int d, input vec_t v, input int exp_lat, input string nm);
    int lat;
    ordy[d] = 1'b1;
    start_op(d, v.ctrl, v.a, v.b);
    wait_done(d, lat);
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_result"}, res[d], v.res);
    chk({nm, "_flags"}, 64'(flg[d]), 64'(fexp(v.nzvc)));
    @(negedge clk);
    chk({nm, "_idle_after"}, 64'({ir[d], ov[d]}), 64'b10);
  endtask

  vec_t vecs [12];

  initial begin
    int lat;
    vecs[0]  = '{ALU_ADD,    64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h0,                   4'b0101};
    vecs[1]  = '{ALU_SUB,    64'h8000_0000_0000_0000, 64'h1,                   64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[2]  = '{ALU_AND,    64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 4'b1000};
    vecs[3]  = '{ALU_OR,     64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0, 4'b1000};
    vecs[4]  = '{ALU_XOR,    64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 4'b0000};
    vecs[5]  = '{ALU_PASS_B, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00, 4'b1000};
    vecs[6]  = '{ALU_SUB,    64'h5,                   64'h5,                   64'h0,                   4'b0101};
    vecs[7]  = '{ALU_ADD,    64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                   64'h8000_0000_0000_0000, 4'b1010};
    vecs[8]  = '{ALU_SUB,    64'h0,                   64'h1,                   64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[9]  = '{3'b001,     64'h1234,                64'h5678,                64'h0,                   4'b0100};
    vecs[10] = '{ALU_ADD,    64'h0000_0000_0000_FFFF, 64'h1,                   64'h0000_0000_0001_0000, 4'b0000};
    vecs[11] = '{ALU_ADD,    64'h0000_FFFF_FFFF_FFFF, 64'h1,                   64'h0001_0000_0000_0000, 4'b0000};

    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
      ia[d] = '0;
      ib[d] = '0;
      ic[d] = '0;
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_handshake", 64'({ir[0], ov[0]}), 64'b10);
    chk("reset_result", res[0], 64'h0);
    chk("reset_flags", 64'(flg[0]), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_vec(0, vecs[i], 5, $sformatf("vec%0d", i));

    // result and flags must hold while the consumer stalls
    ordy[0] = 1'b0;
    start_op(0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    wait_done(0, lat);
    chk("stall_latency", 64'(lat), 64'd5);
    for (int i = 0; i < 3; i++) begin
      chk("stall_handshake", 64'({ir[0], ov[0]}), 64'b01);
      chk("stall_result", res[0], 64'h8000_0000_0000_0000);
      chk("stall_flags", 64'(flg[0]), 64'(fexp(4'b1010)));
      iv[0] = (i != 2);
      ic[0] = ALU_ADD;
      ia[0] = 64'h5;
      ib[0] = 64'h6;
      ordy[0] = (i == 2);
      @(negedge clk);
    end
    chk("stall_release", 64'({ir[0], ov[0]}), 64'b10);
    @(negedge clk);
    chk("stall_no_capture", 64'({ir[0], ov[0]}), 64'b10);

    // reset in the middle of RUN, with slice 2 pending
    ordy[0] = 1'b1;
    start_op(0, ALU_ADD, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_reset_handshake", 64'({ir[0], ov[0]}), 64'b10);
    chk("midrun_reset_result", res[0], 64'h0);
    run_vec(0, '{ALU_ADD, 64'h3, 64'h4, 64'h7, 4'b0000}, 5, "after_reset");

    // single-slice instance
    run_vec(1, '{3'b111, 64'hDEAD_BEEF, 64'h1234, 64'h0, 4'b0100}, 2, "wide_reserved");
    run_vec(1, vecs[0], 2, "wide_add_wrap");
    run_vec(1, vecs[1], 2, "wide_sub_ovf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
